// File: rtl/keyb_pkg.sv
// Shared keypad definitions: matrix geometry, key code width, scanner states
// and the column priority encoder.
package keyb_pkg;

    localparam int unsigned KB_ROWS    = 4;
    localparam int unsigned KB_COLS    = 4;
    localparam int unsigned KEY_CODE_W = 4;
    localparam int unsigned ROW_IDX_W  = 2;
    localparam int unsigned COL_IDX_W  = 2;

    typedef enum logic [0:0] {
        SCAN = 1'b0,
        HOLD = 1'b1
    } kb_state_e;

    typedef struct packed {
        logic                 any;
        logic                 multi;
        logic [COL_IDX_W-1:0] idx;
    } col_enc_t;

    // Lowest-index low column wins; multi flags more than one low column.
    function automatic col_enc_t col_encode(input logic [KB_COLS-1:0] cols_n);
        col_enc_t   r;
        logic [2:0] n;
        r = '0;
        n = '0;
        for (int i = int'(KB_COLS) - 1; i >= 0; i--) begin
            if (!cols_n[i]) begin
                r.idx = COL_IDX_W'(i);
                n     = n + 3'd1;
            end
        end
        r.any   = (n != 3'd0);
        r.multi = (n > 3'd1);
        return r;
    endfunction

endpackage

// File: rtl/keyb_sync2.sv
// Two-flop synchronizer; resets to all-ones so idle pulled-up columns read high.
module keyb_sync2 #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keyb_matrix_scan.sv
// 4x4 keypad row scanner: rotates a one-cold row drive, locks onto the first
// pressed key and holds it until the columns read idle for RELEASE_SAMPLES samples.
module keyb_matrix_scan
    import keyb_pkg::*;
#(
    parameter int unsigned FREQ_HZ         = 50000000,
    parameter int unsigned SCAN_US         = 100,
    parameter int unsigned RELEASE_SAMPLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [KB_COLS-1:0]    col_in,
    output logic [KB_ROWS-1:0]    row_out,
    output logic                  key_pressed,
    output logic [KEY_CODE_W-1:0] key_code,
    output logic                  multi_key
);

    localparam int unsigned ROW_TICKS = (FREQ_HZ / 1000000) * SCAN_US;
    localparam int unsigned TICK_W    = $clog2(ROW_TICKS);
    localparam int unsigned REL_W     = $clog2(RELEASE_SAMPLES + 1);
    localparam logic [TICK_W-1:0] TICK_RELOAD = TICK_W'(ROW_TICKS - 1);
    localparam logic [REL_W-1:0]  REL_LAST    = REL_W'(RELEASE_SAMPLES - 1);

    logic [KB_COLS-1:0]    col_s;
    kb_state_e             state_q,       state_d;
    logic [ROW_IDX_W-1:0]  row_idx_q,     row_idx_d;
    logic [TICK_W-1:0]     tick_q,        tick_d;
    logic [REL_W-1:0]      rel_q,         rel_d;
    logic [KB_ROWS-1:0]    row_out_q,     row_out_d;
    logic                  key_pressed_q, key_pressed_d;
    logic [KEY_CODE_W-1:0] key_code_q,    key_code_d;
    logic                  multi_q,       multi_d;
    logic                  sample;
    col_enc_t              enc;

    keyb_sync2 #(.W(KB_COLS)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (col_in),
        .q_o   (col_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= SCAN;
            row_idx_q     <= '0;
            tick_q        <= TICK_RELOAD;
            rel_q         <= '0;
            row_out_q     <= 4'b1110;
            key_pressed_q <= 1'b0;
            key_code_q    <= '0;
            multi_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_idx_q     <= row_idx_d;
            tick_q        <= tick_d;
            rel_q         <= rel_d;
            row_out_q     <= row_out_d;
            key_pressed_q <= key_pressed_d;
            key_code_q    <= key_code_d;
            multi_q       <= multi_d;
        end
    end

    // Sample point is tick==0; the row only moves on a sample, so the drive
    // has the whole dwell (minus synchronizer delay) to settle.
    always_comb begin
        state_d       = state_q;
        row_idx_d     = row_idx_q;
        rel_d         = rel_q;
        key_pressed_d = key_pressed_q;
        key_code_d    = key_code_q;
        multi_d       = multi_q;
        sample        = (tick_q == '0);
        enc           = col_encode(col_s);
        tick_d        = sample ? TICK_RELOAD : tick_q - TICK_W'(1);

        unique case (state_q)
            SCAN: begin
                if (sample) begin
                    if (enc.any) begin
                        state_d       = HOLD;
                        key_code_d    = KEY_CODE_W'({row_idx_q, enc.idx});
                        multi_d       = enc.multi;
                        key_pressed_d = 1'b1;
                    end else begin
                        row_idx_d = row_idx_q + ROW_IDX_W'(1);
                    end
                end
            end
            HOLD: begin
                if (sample) begin
                    if (enc.any) begin
                        rel_d = '0;
                    end else if (rel_q == REL_LAST) begin
                        rel_d         = '0;
                        key_pressed_d = 1'b0;
                        row_idx_d     = row_idx_q + ROW_IDX_W'(1);
                        state_d       = SCAN;
                    end else begin
                        rel_d = rel_q + REL_W'(1);
                    end
                end
            end
            default: state_d = SCAN;
        endcase

        row_out_d = ~(KB_ROWS'(1) << row_idx_d);
    end

    assign row_out     = row_out_q;
    assign key_pressed = key_pressed_q;
    assign key_code    = key_code_q;
    assign multi_key   = multi_q;

endmodule

// File: tb/tb_keyb_matrix_scan.sv
// Bench for keyb_matrix_scan: cycle-indexed vector table plus a lock scoreboard.
module tb_keyb_matrix_scan;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  col_in;
    logic [3:0]  row_out;
    logic        key_pressed;
    logic [3:0]  key_code;
    logic        multi_key;
    logic [15:0] press;

    always #5 clk = ~clk;

    keyb_matrix_scan #(
        .FREQ_HZ         (1000000),
        .SCAN_US         (10),
        .RELEASE_SAMPLES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .col_in      (col_in),
        .row_out     (row_out),
        .key_pressed (key_pressed),
        .key_code    (key_code),
        .multi_key   (multi_key)
    );

    // Keypad: pressed key (r,c) = press[r*4+c] pulls column c low while row r is driven.
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (press[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
    end

    typedef struct {
        int         cyc;
        logic [15:0] press;
        logic [3:0] row;
        logic       kp;
        logic [3:0] code;
        logic       multi;
        logic       push;
        logic [3:0] lk_code;
        logic       lk_multi;
    } vec_t;

    typedef struct {
        logic [3:0] code;
        logic       multi;
    } lock_t;

    vec_t  vecs[$];
    lock_t sb[$];
    int    n_cmp;
    int    n_bad;
    int    cyc;
    int    lock_cyc;
    logic  prev_kp;

    function automatic void add(input int c, input logic [15:0] p, input logic [3:0] r,
                                input logic k, input logic [3:0] cd, input logic m,
                                input logic pu, input logic [3:0] lc, input logic lm);
        vec_t v;
        v.cyc = c; v.press = p; v.row = r; v.kp = k; v.code = cd; v.multi = m;
        v.push = pu; v.lk_code = lc; v.lk_multi = lm;
        vecs.push_back(v);
    endfunction

    function automatic void sb_push(input logic [3:0] c, input logic m);
        lock_t l;
        l.code = c;
        l.multi = m;
        sb.push_back(l);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0d, want %0d", nm, cyc, act, exp);
        end
    endtask

    // One clock; a rising key_pressed pops the scoreboard.
    task automatic step();
        lock_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (key_pressed && !prev_kp) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_lock @cyc %0d: got code %0d, want no lock", cyc, key_code);
            end else begin
                e = sb.pop_front();
                chk("lock_code", int'(key_code), int'(e.code));
                chk("lock_multi", int'(multi_key), int'(e.multi));
            end
        end
        prev_kp = key_pressed;
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        cyc     = 0;
        prev_kp = 1'b0;
        press   = '0;
        reset   = 1'b1;

        //  cyc  press-after  row    kp    code   multi push lk_code lk_multi
        add(0,   16'h0000, 4'hE, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        add(9,   16'h0000, 4'hE, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        add(10,  16'h0000, 4'hD, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        add(19,  16'h0000, 4'hD, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        add(20,  16'h0000, 4'hB, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        add(30,  16'h0000, 4'h7, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        add(39,  16'h0000, 4'h7, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        add(40,  16'h0200, 4'hE, 1'b0, 4'd0, 1'b0, 1'b1, 4'd9, 1'b0);
        add(69,  16'h0200, 4'hB, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        add(70,  16'h0200, 4'hB, 1'b1, 4'd9, 1'b0, 1'b0, 4'd0, 1'b0);
        add(120, 16'h0200, 4'hB, 1'b1, 4'd9, 1'b0, 1'b0, 4'd0, 1'b0);
        add(170, 16'h0000, 4'hB, 1'b1, 4'd9, 1'b0, 1'b0, 4'd0, 1'b0);
        add(180, 16'h0000, 4'hB, 1'b1, 4'd9, 1'b0, 1'b0, 4'd0, 1'b0);
        add(189, 16'h0000, 4'hB, 1'b1, 4'd9, 1'b0, 1'b0, 4'd0, 1'b0);
        add(190, 16'h0090, 4'h7, 1'b0, 4'd9, 1'b0, 1'b1, 4'd4, 1'b1);
        add(219, 16'h0090, 4'hD, 1'b0, 4'd9, 1'b0, 1'b0, 4'd0, 1'b0);
        add(220, 16'h4090, 4'hD, 1'b1, 4'd4, 1'b1, 1'b0, 4'd0, 1'b0);
        add(250, 16'h4000, 4'hD, 1'b1, 4'd4, 1'b1, 1'b0, 4'd0, 1'b0);
        add(260, 16'h4090, 4'hD, 1'b1, 4'd4, 1'b1, 1'b0, 4'd0, 1'b0);
        add(270, 16'h4000, 4'hD, 1'b1, 4'd4, 1'b1, 1'b0, 4'd0, 1'b0);
        add(280, 16'h4090, 4'hD, 1'b1, 4'd4, 1'b1, 1'b0, 4'd0, 1'b0);
        add(290, 16'h4090, 4'hD, 1'b1, 4'd4, 1'b1, 1'b0, 4'd0, 1'b0);
        add(295, 16'h4090, 4'hD, 1'b1, 4'd4, 1'b1, 1'b0, 4'd0, 1'b0);

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        foreach (vecs[i]) begin
            while (cyc < vecs[i].cyc) step();
            chk("row_out",     int'(row_out),     int'(vecs[i].row));
            chk("key_pressed", int'(key_pressed), int'(vecs[i].kp));
            chk("key_code",    int'(key_code),    int'(vecs[i].code));
            chk("multi_key",   int'(multi_key),   int'(vecs[i].multi));
            press = vecs[i].press;
            if (vecs[i].push) sb_push(vecs[i].lk_code, vecs[i].lk_multi);
        end

        // Asynchronous reset in the middle of a hold, key still pressed.
        reset = 1'b1;
        #1;
        chk("rst_row_out",     int'(row_out),     14);
        chk("rst_key_pressed", int'(key_pressed), 0);
        chk("rst_key_code",    int'(key_code),    0);
        chk("rst_multi_key",   int'(multi_key),   0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        cyc      = 0;
        prev_kp  = 1'b0;
        lock_cyc = -1;
        sb_push(4'd4, 1'b1);
        for (int i = 0; i < 60 && lock_cyc < 0; i++) begin
            step();
            if (key_pressed) lock_cyc = cyc;
        end
        chk("relock_cycle", lock_cyc, 20);
        chk("relock_row",   int'(row_out), 13);
        chk("sb_drained",   sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
